// File: rtl/reg_dump.sv
// reg_dump: walks the register file debug read port over a programmable,
// wrapping address range and streams each captured word over valid/ready.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; counter holds its last address
// READ  | counter drives testRegAddress; exit edge captures data/addr/last
// SEND  | beat presented on dump_*; holds until dump_ready
// DONE  | one-cycle done pulse, then back to IDLE
module reg_dump #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] first_reg,
  input  logic [ADDRESS_WIDTH-1:0] last_reg,
  output logic [ADDRESS_WIDTH-1:0] testRegAddress,
  input  logic [DATA_WIDTH-1:0]    testRegData,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [DATA_WIDTH-1:0]    dump_data,
  output logic [ADDRESS_WIDTH-1:0] dump_addr,
  output logic                     dump_last,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     dlast_q, dlast_d;

  // Next-state and capture logic; output holding regs move only on READ exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    addr_d  = addr_q;
    dlast_d = dlast_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = first_reg;
          last_d  = last_reg;
          state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = testRegData;
        addr_d  = cnt_q;
        dlast_d = (cnt_q == last_q);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dump_ready) begin
          if (dlast_q) begin
            state_d = S_DONE;
          end else begin
            // Natural overflow gives the modulo-2**ADDRESS_WIDTH wrap.
            cnt_d   = cnt_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and holding registers; synchronous reset aborts any dump in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      dlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      dlast_q <= dlast_d;
    end
  end

  assign testRegAddress = cnt_q;
  assign dump_data      = data_q;
  assign dump_addr      = addr_q;
  assign dump_last      = dlast_q;
  assign dump_valid     = (state_q == S_SEND);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Directed testbench for reg_dump with a combinational register file model.
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  testRegAddress;
  logic [31:0] testRegData;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [4:0]  dump_addr;
  logic        dump_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [31:0] b_data [64];
  logic [4:0]  b_addr [64];
  logic        b_last [64];

  int cyc = 0;
  int start_cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  reg_dump #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .first_reg      (first_reg),
    .last_reg       (last_reg),
    .testRegAddress (testRegAddress),
    .testRegData    (testRegData),
    .dump_valid     (dump_valid),
    .dump_ready     (dump_ready),
    .dump_data      (dump_data),
    .dump_addr      (dump_addr),
    .dump_last      (dump_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign testRegData = regs[testRegAddress];

  function automatic logic [31:0] preload(input int i);
    return (i == 0) ? 32'h0 : 32'h1000_0000 + i;
  endfunction

  // Start pulse in cycle 0 (sampled at E0); returns at the negedge of cycle 1.
  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    first_reg  = f;
    last_reg   = l;
    start      = 1'b1;
    dump_ready = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives dump_ready, records accepted beats, optionally stalls one address.
  task automatic collect(input int stall_addr, input int stall_len,
                         output int n, output int done_cyc,
                         output int done_pulses, output int stall_bad,
                         output int timeout);
    int stalls;
    logic [31:0] h_data;
    logic [4:0]  h_addr;
    n = 0; done_cyc = -1; done_pulses = 0; stall_bad = 0; timeout = 1;
    stalls = 0; h_data = '0; h_addr = '0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        done_pulses++;
        done_cyc = cyc - start_cyc;
      end
      if (!busy && done_pulses > 0) begin
        timeout = 0;
        break;
      end
      if (dump_valid) begin
        if (int'(dump_addr) == stall_addr && stalls < stall_len) begin
          if (stalls == 0) begin
            h_data = dump_data;
            h_addr = dump_addr;
          end else if (dump_data !== h_data || dump_addr !== h_addr) begin
            stall_bad++;
          end
          dump_ready = 1'b0;
          stalls++;
        end else begin
          if (stall_len > 0 && stalls == stall_len && int'(dump_addr) == stall_addr
              && dump_data !== h_data)
            stall_bad++;
          dump_ready = 1'b1;
          if (n < 64) begin
            b_data[n] = dump_data;
            b_addr[n] = dump_addr;
            b_last[n] = dump_last;
          end
          n++;
        end
      end else begin
        if (stalls > 0 && stalls < stall_len) stall_bad++;
        dump_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({dump_valid, busy, done, dump_last} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {dump_valid, busy, done, dump_last});
    else pass_cnt++;
    total_cnt++;
    if (dump_data !== 32'h0) $display("FAIL reset_data: got %h want 0", dump_data);
    else pass_cnt++;
    total_cnt++;
    if (dump_addr !== 5'd0 || testRegAddress !== 5'd0)
      $display("FAIL reset_addr: got %0d/%0d want 0/0", dump_addr, testRegAddress);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_full_dump();
    int n, dc, dp, sb, to, bad;
    do_start(5'd0, 5'd31);
    collect(-1, 0, n, dc, dp, sb, to);
    total_cnt++;
    if (to != 0 || n != 32) $display("FAIL full_count: got %0d beats (timeout %0d) want 32", n, to);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 32 && i < n; i++)
      if (b_addr[i] !== 5'(i) || b_data[i] !== preload(i) || b_last[i] !== (i == 31)) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL full_beats: got %0d bad beats want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (dc != 65 || dp != 1) $display("FAIL full_done: got cycle %0d pulses %0d want 65/1", dc, dp);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n, dc, dp, sb, to, bad;
    do_start(5'd0, 5'd31);
    collect(3, 5, n, dc, dp, sb, to);
    total_cnt++;
    if (sb != 0) $display("FAIL bp_hold: got %0d unstable stall cycles want 0", sb);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 32 && i < n; i++)
      if (b_addr[i] !== 5'(i) || b_data[i] !== preload(i)) bad++;
    total_cnt++;
    if (n != 32 || bad != 0) $display("FAIL bp_beats: got %0d beats %0d bad want 32/0", n, bad);
    else pass_cnt++;
    total_cnt++;
    if (dc != 70) $display("FAIL bp_done: got cycle %0d want 70", dc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int n, dc, dp, sb, to;
    do_start(5'd30, 5'd1);
    collect(-1, 0, n, dc, dp, sb, to);
    total_cnt++;
    if (n != 4) $display("FAIL wrap_count: got %0d want 4", n);
    else pass_cnt++;
    total_cnt++;
    if (n < 4 || b_addr[0] !== 5'd30 || b_addr[1] !== 5'd31 || b_addr[2] !== 5'd0 || b_addr[3] !== 5'd1)
      $display("FAIL wrap_addr: got %0d,%0d,%0d,%0d want 30,31,0,1", b_addr[0], b_addr[1], b_addr[2], b_addr[3]);
    else pass_cnt++;
    total_cnt++;
    if ({b_last[0], b_last[1], b_last[2], b_last[3]} !== 4'b0001 || b_data[1] !== 32'h1000_001F)
      $display("FAIL wrap_last: got %b data %h want 0001 1000001f",
               {b_last[0], b_last[1], b_last[2], b_last[3]}, b_data[1]);
    else pass_cnt++;
    total_cnt++;
    if (dc != 9) $display("FAIL wrap_done: got cycle %0d want 9", dc);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int n, dc, dp, sb, to;
    @(negedge clk);
    regs[10] <= 32'hDEAD_BEEF;
    do_start(5'd10, 5'd10);
    collect(-1, 0, n, dc, dp, sb, to);
    total_cnt++;
    if (n != 1 || b_data[0] !== 32'hDEAD_BEEF || b_last[0] !== 1'b1)
      $display("FAIL single_beat: got n=%0d data=%h last=%b want 1 deadbeef 1", n, b_data[0], b_last[0]);
    else pass_cnt++;
    total_cnt++;
    if (dc != 3) $display("FAIL single_done: got cycle %0d want 3", dc);
    else pass_cnt++;
    total_cnt++;
    if (testRegAddress !== 5'd10 || busy !== 1'b0)
      $display("FAIL idle_hold: got addr %0d busy %b want 10 0", testRegAddress, busy);
    else pass_cnt++;
  endtask

  task automatic test_concurrent_write();
    int n, dc, dp, sb, to;
    @(negedge clk);
    regs[5] <= 32'h5555_5555;
    do_start(5'd5, 5'd5);
    @(posedge clk);
    regs[5] <= 32'hAAAA_AAAA;
    @(negedge clk);
    collect(-1, 0, n, dc, dp, sb, to);
    total_cnt++;
    if (n != 1 || b_data[0] !== 32'h5555_5555)
      $display("FAIL cw_old: got n=%0d data=%h want 1 55555555", n, b_data[0]);
    else pass_cnt++;
    do_start(5'd5, 5'd5);
    collect(-1, 0, n, dc, dp, sb, to);
    total_cnt++;
    if (n != 1 || b_data[0] !== 32'hAAAA_AAAA)
      $display("FAIL cw_new: got n=%0d data=%h want 1 aaaaaaaa", n, b_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int n, dc, dp, sb, to;
    do_start(5'd0, 5'd3);
    first_reg = 5'd20;
    last_reg  = 5'd25;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(-1, 0, n, dc, dp, sb, to);
    total_cnt++;
    if (n != 4 || b_addr[0] !== 5'd0 || b_addr[3] !== 5'd3 || b_last[3] !== 1'b1)
      $display("FAIL start_busy: got n=%0d first %0d last %0d want 4 0 3", n, b_addr[0], b_addr[3]);
    else pass_cnt++;
    total_cnt++;
    if (dc != 9) $display("FAIL start_busy_done: got cycle %0d want 9", dc);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_dump();
    int n, dc, dp, sb, to, dseen;
    do_start(5'd0, 5'd31);
    dump_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dump_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", dump_valid);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({dump_valid, busy, done} !== 3'b000 || testRegAddress !== 5'd0)
      $display("FAIL rst_abort: got vbd=%b addr=%0d want 000 0", {dump_valid, busy, done}, testRegAddress);
    else pass_cnt++;
    dseen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) dseen++;
      @(negedge clk);
    end
    total_cnt++;
    if (dseen != 0) $display("FAIL rst_no_done: got %0d active cycles want 0", dseen);
    else pass_cnt++;
    do_start(5'd7, 5'd8);
    collect(-1, 0, n, dc, dp, sb, to);
    total_cnt++;
    if (n != 2 || b_addr[0] !== 5'd7 || b_data[1] !== 32'h1000_0008 || b_last[1] !== 1'b1 || dc != 5)
      $display("FAIL rst_restart: got n=%0d addr0=%0d data1=%h done=%0d want 2 7 10000008 5",
               n, b_addr[0], b_data[1], dc);
    else pass_cnt++;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    first_reg  = '0;
    last_reg   = '0;
    dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] <= preload(i);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_wrap();
    test_single();
    test_concurrent_write();
    test_start_ignored();
    test_rst_mid_dump();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential register-file dump engine for the RISC-V core test harness. On a `start` pulse it walks the register file's debug read port (`testRegAddress`/`testRegData`) over a programmable address range. It captures each register into an output holding register and streams it out over a valid/ready interface. It is the reading end of the register file's test port, used by benches and the debug link to snapshot architectural state without stalling the core.

## Interface
- `DATA_WIDTH`, 32, register width in bits.
- `ADDRESS_WIDTH`, 5, register address width; range wraps modulo 2**ADDRESS_WIDTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `first_reg`  in  ADDRESS_WIDTH  first address of range; latched on accepted start.
- `last_reg`  in  ADDRESS_WIDTH  last address of range; latched on accepted start.
- `testRegAddress`  out  ADDRESS_WIDTH  to register file debug read address.
- `testRegData`  in  DATA_WIDTH  from register file; combinational read of `testRegAddress`.
- `dump_valid`  out  1  beat available.
- `dump_ready`  in  1  sink accepts beat.
- `dump_data`  out  DATA_WIDTH  captured register value.
- `dump_addr`  out  ADDRESS_WIDTH  address of captured value.
- `dump_last`  out  1  beat is final of range.
- `busy`  out  1  dump in progress (state != IDLE).
- `done`  out  1  one-cycle pulse after final beat accepted.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `start`=1 latches `first_reg`/`last_reg` and sets address counter to `first_reg`, then goes to READ. A `start` arriving in any other state is ignored.
- READ: `testRegAddress` = counter. The edge leaving READ captures `testRegData` into `dump_data` and counter into `dump_addr`. `dump_last` is set iff counter == latched last. Next state is SEND.
- SEND: `dump_valid`=1.
  - On `dump_valid && dump_ready`, if `dump_last` go to DONE; else counter <= counter+1 (wraps modulo 2**ADDRESS_WIDTH) and go to READ.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Range: words = ((last - first) mod 2**ADDRESS_WIDTH) + 1. first > last wraps through the top address. first == last gives one word.
- Output regs `dump_data`/`dump_addr`/`dump_last` change only at the READ exit edge. They are stable throughout SEND regardless of `dump_ready`.
- `testRegAddress` always equals the counter, including in IDLE where it holds its last value.
- Coherence: the value captured is the register file content during the READ cycle. A core write landing at the same edge is not captured (old value is dumped). The dump is not atomic across registers.
- `dump_valid` never deasserts in SEND without a handshake.

## Timing
- Reset values (after the edge with `rst`=1): state IDLE, counter 0, `testRegAddress` 0, `dump_valid` 0, `dump_data` 0, `dump_addr` 0, `dump_last` 0, `busy` 0, `done` 0.
- `rst` mid-dump aborts at that edge; no `done` pulse. `rst` has priority over `start` and handshakes.
- `start` sampled at edge E0 leads to READ in cycle 1 (`busy`=1), then `dump_valid`=1 in cycle 2.
- Per word: 1 READ cycle + ≥1 SEND cycle. Throughput is 1 word / 2 cycles with `dump_ready` held high.
- Latency for N words with `dump_ready`=1: final handshake at edge E(2N), `done` high in cycle 2N+1, IDLE (`busy`=0) in cycle 2N+2. The earliest accepted restart is at edge E(2N+2).

## Test plan
- Full dump: preload x1..x31 = 0x1000_0000+i, `first_reg`=0, `last_reg`=31, `dump_ready`=1 → 32 beats, `dump_addr` 0..31 in order, data match, `dump_last` only on addr 31, `done` in cycle 65.
- Backpressure: same range, `dump_ready`=0 for 5 cycles when beat addr 3 is valid → `dump_valid` held, `dump_data`/`dump_addr` unchanged, no beat skipped or duplicated.
- Wrap range: `first_reg`=30, `last_reg`=1 → exactly 4 beats, addrs 30,31,0,1, `dump_last` on 1.
- Single word: `first_reg`=`last_reg`=10, x10=0xDEAD_BEEF → one beat 0xDEAD_BEEF with `dump_last`=1, `done` in cycle 3.
- Concurrent write: write x5=0xAAAA_AAAA (old 0x5555_5555) at the edge ending the READ cycle of addr 5 → beat carries 0x5555_5555. A second dump returns 0xAAAA_AAAA.
- Control: `start` pulsed while `busy` → ignored, range unchanged. `rst` during SEND → next cycle `dump_valid`=0, `busy`=0, no `done`. A fresh `start` then dumps normally.
